// File: rtl/mem_arbiter_if.sv
// Core-side request/grant signals and the shared memory port of the arbiter.
// The master modport is the arbiter; the slave modport is the cores plus memory.
interface mem_arbiter_if #(
  parameter int CORES      = 4,
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 12
) ();
  logic [CORES-1:0]            req;
  logic [CORES-1:0]            wrEn;
  logic [CORES*ADDR_WIDTH-1:0] addr;
  logic [CORES*DATA_WIDTH-1:0] wdata;
  logic [CORES-1:0]            gnt;
  logic [CORES-1:0]            done;
  logic [DATA_WIDTH-1:0]       rdata;
  logic                        zero;
  logic                        busy;
  logic                        mem_en;
  logic                        mem_wrEn;
  logic [ADDR_WIDTH-1:0]       mem_addr;
  logic [DATA_WIDTH-1:0]       mem_wdata;
  logic [DATA_WIDTH-1:0]       mem_rdata;

  modport master (
    input  req, wrEn, addr, wdata, mem_rdata,
    output gnt, done, rdata, zero, busy, mem_en, mem_wrEn, mem_addr, mem_wdata
  );

  modport slave (
    output req, wrEn, addr, wdata, mem_rdata,
    input  gnt, done, rdata, zero, busy, mem_en, mem_wrEn, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter giving CORES requesters single-access turns at a shared
// synchronous memory; every output is a flop so reset clears them immediately.
//
// state | meaning
// IDLE  | no access; pick next requester round-robin, latch its command
// ISSUE | mem_en strobe with the latched command
// WAIT  | memory returns read data; capture it for reads
// RESP  | done pulse to the granted core, then back to IDLE
module mem_arbiter #(
  parameter int CORES      = 4,
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 12
) (
  input  logic         clk,
  input  logic         rstN,
  mem_arbiter_if.master bus
);
  localparam int PW = (CORES > 1) ? $clog2(CORES) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t                  state_q, state_d;
  logic [PW-1:0]           ptr_q, ptr_d;
  logic [PW-1:0]           win;
  logic                    found;
  int                      idx;
  logic [CORES-1:0]        gnt_q, gnt_d;
  logic [CORES-1:0]        done_q, done_d;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
  logic                    zero_q, zero_d;
  logic                    busy_q, busy_d;
  logic                    mem_en_q, mem_en_d;
  logic                    mem_wr_q, mem_wr_d;
  logic [ADDR_WIDTH-1:0]   maddr_q, maddr_d;
  logic [DATA_WIDTH-1:0]   mwdata_q, mwdata_d;
  logic                    lat_wr_q, lat_wr_d;

  // Search starts one past the last winner so every pending core is reached.
  always_comb begin
    found = 1'b0;
    win   = ptr_q;
    idx   = 0;
    for (int i = 1; i <= CORES; i++) begin
      idx = (int'(ptr_q) + i) % CORES;
      if (!found && bus.req[idx]) begin
        found = 1'b1;
        win   = PW'(idx);
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    gnt_d    = gnt_q;
    done_d   = '0;
    rdata_d  = rdata_q;
    zero_d   = zero_q;
    mem_en_d = 1'b0;
    mem_wr_d = 1'b0;
    maddr_d  = maddr_q;
    mwdata_d = mwdata_q;
    lat_wr_d = lat_wr_q;
    unique case (state_q)
      IDLE: begin
        gnt_d = '0;
        if (found) begin
          state_d    = ISSUE;
          ptr_d      = win;
          gnt_d[win] = 1'b1;
          lat_wr_d   = bus.wrEn[win];
          mem_en_d   = 1'b1;
          mem_wr_d   = bus.wrEn[win];
          maddr_d    = bus.addr[int'(win)*ADDR_WIDTH +: ADDR_WIDTH];
          mwdata_d   = bus.wdata[int'(win)*DATA_WIDTH +: DATA_WIDTH];
        end
      end
      ISSUE: state_d = WAIT;
      WAIT: begin
        if (!lat_wr_q) begin
          rdata_d = bus.mem_rdata;
          zero_d  = (bus.mem_rdata == '0);
        end
        done_d  = gnt_q;
        state_d = RESP;
      end
      RESP: begin
        gnt_d   = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state_q  <= IDLE;
      ptr_q    <= PW'(CORES - 1);
      gnt_q    <= '0;
      done_q   <= '0;
      rdata_q  <= '0;
      zero_q   <= 1'b1;
      busy_q   <= 1'b0;
      mem_en_q <= 1'b0;
      mem_wr_q <= 1'b0;
      maddr_q  <= '0;
      mwdata_q <= '0;
      lat_wr_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      gnt_q    <= gnt_d;
      done_q   <= done_d;
      rdata_q  <= rdata_d;
      zero_q   <= zero_d;
      busy_q   <= busy_d;
      mem_en_q <= mem_en_d;
      mem_wr_q <= mem_wr_d;
      maddr_q  <= maddr_d;
      mwdata_q <= mwdata_d;
      lat_wr_q <= lat_wr_d;
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.done      = done_q;
  assign bus.rdata     = rdata_q;
  assign bus.zero      = zero_q;
  assign bus.busy      = busy_q;
  assign bus.mem_en    = mem_en_q;
  assign bus.mem_wrEn  = mem_wr_q;
  assign bus.mem_addr  = maddr_q;
  assign bus.mem_wdata = mwdata_q;
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter CORES, default 4: number of requesting cores, range 2..8.
REQ-002 Parameter ADDR_WIDTH, default 8: shared data-memory address width.
REQ-003 Parameter DATA_WIDTH, default 12: data word width.
REQ-004 Port clk  input  1: single clock; all state updates on its rising edge.
REQ-005 Port rstN  input  1: reset, asynchronous, active-low.
REQ-006 Port req  input  CORES: per-core access request, level.
REQ-007 Port wrEn  input  CORES: per-core access type, 1 = write, 0 = read.
REQ-008 Port addr  input  CORES*ADDR_WIDTH: per-core address, core i in bits [i*ADDR_WIDTH +: ADDR_WIDTH].
REQ-009 Port wdata  input  CORES*DATA_WIDTH: per-core write data, same packing as addr.
REQ-010 Port gnt  output  CORES: one-hot grant, all-zero when idle.
REQ-011 Port done  output  CORES: one-cycle completion pulse to the granted core.
REQ-012 Port rdata  output  DATA_WIDTH: read data returned with done.
REQ-013 Port zero  output  1: high when the captured rdata equals 0.
REQ-014 Port busy  output  1: high in every state except IDLE.
REQ-015 Port mem_en  output  1: memory access strobe.
REQ-016 Port mem_wrEn  output  1: memory write enable, valid only with mem_en.
REQ-017 Port mem_addr  output  ADDR_WIDTH: memory address.
REQ-018 Port mem_wdata  output  DATA_WIDTH: memory write data.
REQ-019 Port mem_rdata  input  DATA_WIDTH: memory read data, valid one cycle after mem_en.

Function
REQ-020 FSM states: IDLE, ISSUE, WAIT, RESP; all outputs registered.
REQ-021 IDLE: if req is non-zero, select winner g by round-robin, set gnt to one-hot g, latch addr, wdata and wrEn of core g, go to ISSUE; otherwise stay in IDLE with gnt = 0.
REQ-022 Round-robin: search order ptr+1, ptr+2, ... modulo CORES; ptr updates to g when granted.
REQ-023 ISSUE (one cycle): mem_en = 1, mem_wrEn = latched wrEn, mem_addr/mem_wdata = latched values; go to WAIT.
REQ-024 WAIT (one cycle): mem_en = 0, mem_wrEn = 0; capture mem_rdata into rdata and set zero = (mem_rdata == 0) for reads; for writes rdata and zero hold their previous values; go to RESP.
REQ-025 RESP (one cycle): done[g] = 1; go to IDLE; gnt drops to 0 on entering IDLE.
REQ-026 Latency: req first sampled high at edge T0 -> mem_en high during cycle T0+1, done high during cycle T0+3; 4 cycles per access, including the IDLE cycle.
REQ-027 Requester handshake: hold req, wrEn, addr and wdata stable until done; deassert req on the edge at which done is sampled high.
REQ-028 Changes on req or data inputs of non-granted cores, or of the granted core after the IDLE latch, do not affect the access in flight.
REQ-029 Simultaneous requests: exactly one grant per access; losers stay pending and are served in round-robin order.
REQ-030 A core whose req drops before it is granted is not served; no state is retained for it.
REQ-031 gnt and done are never non-zero for more than one core.

Reset
REQ-032 On rstN low: immediately state = IDLE, gnt = 0, done = 0, rdata = 0, zero = 1, busy = 0, mem_en = 0, mem_wrEn = 0, mem_addr = 0, mem_wdata = 0, ptr = CORES-1 (core 0 wins first).
REQ-033 Reset mid-access aborts the access: no done pulse is issued, and a write in ISSUE is dropped asynchronously.
REQ-034 The first rising edge with rstN high evaluates IDLE normally.

Verification
REQ-035 After reset, core 2 writes addr 0x10 with data 0x0A5: mem_en and mem_wrEn high for exactly one cycle with mem_addr 0x10 and mem_wdata 0x0A5; done[2] is high 3 cycles after the req sample; gnt = 4'b0100 throughout.
REQ-036 Core 1 reads addr 0x10 with the memory model returning 0x0A5: rdata = 0x0A5, zero = 0 during done[1]; a read returning 0 gives zero = 1.
REQ-037 All four cores request continuously from reset: grant order 0,1,2,3,0, each access 4 cycles; gnt is always one-hot or zero.
REQ-038 Cores 1 and 3 request after core 1 was last served: core 3 is granted before core 1.
REQ-039 rstN pulled low during ISSUE of a write: mem_wrEn falls with no clock edge, done stays 0, and after release core 0 is granted first.
REQ-040 Random stimulus for 500 cycles against a memory model: every completed read returns the last value written to that address, and no request with req held is starved beyond CORES accesses.
